exp_pin_arb: RTL and testbench



---
 rtl/exp_arb_pkg.sv | 25 ++
 rtl/exp_pin_arb_rr_pick.sv | 29 ++
 rtl/exp_pin_arb.sv | 129 ++++++++++++
 tb/tb_exp_pin_arb.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/exp_arb_pkg.sv
// Shared types and helpers for the expansion-pin arbiter: state encoding,
// requester-count limits and one-hot to index conversion.
package exp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;
    localparam int IDXW     = $clog2(NREQ_MAX);

    // Index of the set bit; the highest set bit wins if more than one is set.
    function automatic logic [IDXW-1:0] onehot2idx(input logic [NREQ_MAX-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/exp_pin_arb_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after ptr,
// wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] elig,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    int c;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        c     = 0;
        for (int i = 0; i < NREQ; i++) begin
            c = int'(ptr) + i;
            if (c >= NREQ) c = c - NREQ;
            if (!valid && elig[c]) begin
                valid = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/exp_pin_arb.sv
// Round-robin owner arbitration for the exp_p connector pins with hold-time
// limit, one-cycle release guard and registered glitch-free pin outputs.
module exp_pin_arb
    import exp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DWE  = 8,
    parameter int HW   = 16
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              arb_en_i,
    input  logic [HW-1:0]     hold_max_i,
    input  logic [DWE-1:0]    dflt_dat_i,
    input  logic [DWE-1:0]    dflt_dir_i,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ*DWE-1:0] req_mask_i,
    input  logic [NREQ*DWE-1:0] req_dat_i,
    input  logic [NREQ*DWE-1:0] req_dir_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic              busy_o,
    output logic              timeout_o,
    output logic [NREQ-1:0]   lockout_o,
    output logic [DWE-1:0]    exp_p_dat_o,
    output logic [DWE-1:0]    exp_p_dir_o
);

    localparam int IW = $clog2(NREQ);

    generate
        if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_bad_nreq
            $error("exp_pin_arb: NREQ out of range");
        end
    endgenerate

    arb_state_e      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d, lockout_q, lockout_d, elig;
    logic [IW-1:0]   ptr_q, ptr_d, pick, own;
    logic [HW-1:0]   hold_q, hold_d;
    logic            pick_vld, tmo_q, tmo_d;
    logic [DWE-1:0]  mask_g, dat_g, dir_g;

    assign elig = req_i & ~lockout_q;
    assign own  = IW'(onehot2idx(NREQ_MAX'(gnt_q)));

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .elig  (elig),
        .ptr   (ptr_q),
        .valid (pick_vld),
        .idx   (pick)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        tmo_d     = 1'b0;
        // A requester clears its own lockout by dropping its request.
        lockout_d = lockout_q & req_i;
        case (state_q)
            IDLE: begin
                if (arb_en_i && pick_vld) begin
                    state_d = GRANT;
                    gnt_d   = NREQ'(1) << pick;
                    hold_d  = HW'(1);
                    ptr_d   = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
                end
            end
            GRANT: begin
                if (!req_i[own] || !arb_en_i) begin
                    state_d = RELEASE;
                    gnt_d   = '0;
                end else if (hold_max_i != '0 && hold_q >= hold_max_i) begin
                    state_d        = RELEASE;
                    gnt_d          = '0;
                    tmo_d          = 1'b1;
                    lockout_d[own] = 1'b1;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            tmo_q     <= 1'b0;
            lockout_q <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            lockout_q <= lockout_d;
        end
    end

    // Owner data is sampled live; pins lag the registered grant by one cycle.
    assign mask_g = req_mask_i[own*DWE +: DWE];
    assign dat_g  = req_dat_i[own*DWE +: DWE];
    assign dir_g  = req_dir_i[own*DWE +: DWE];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            exp_p_dat_o <= '0;
            exp_p_dir_o <= '0;
        end else if (|gnt_q) begin
            exp_p_dat_o <= (mask_g & dat_g) | (~mask_g & dflt_dat_i);
            exp_p_dir_o <= (mask_g & dir_g) | (~mask_g & dflt_dir_i);
        end else begin
            exp_p_dat_o <= dflt_dat_i;
            exp_p_dir_o <= dflt_dir_i;
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = (state_q != IDLE);
    assign timeout_o = tmo_q;
    assign lockout_o = lockout_q;

endmodule

// File: tb/tb_exp_pin_arb.sv
// Directed bench for exp_pin_arb: grant order, hold timeout, lockout,
// enable drop, asynchronous reset and pin muxing.
module tb_exp_pin_arb;

    localparam int NREQ = 4;
    localparam int DWE  = 8;
    localparam int HW   = 16;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              arb_en_i;
    logic [HW-1:0]     hold_max_i;
    logic [DWE-1:0]    dflt_dat_i, dflt_dir_i;
    logic [NREQ-1:0]   req_i;
    logic [NREQ*DWE-1:0] req_mask_i, req_dat_i, req_dir_i;
    logic [NREQ-1:0]   gnt_o, lockout_o;
    logic              busy_o, timeout_o;
    logic [DWE-1:0]    exp_p_dat_o, exp_p_dir_o;

    int nvec = 0;
    int nerr = 0;

    exp_pin_arb #(.NREQ(NREQ), .DWE(DWE), .HW(HW)) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .arb_en_i    (arb_en_i),
        .hold_max_i  (hold_max_i),
        .dflt_dat_i  (dflt_dat_i),
        .dflt_dir_i  (dflt_dir_i),
        .req_i       (req_i),
        .req_mask_i  (req_mask_i),
        .req_dat_i   (req_dat_i),
        .req_dir_i   (req_dir_i),
        .gnt_o       (gnt_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o),
        .lockout_o   (lockout_o),
        .exp_p_dat_o (exp_p_dat_o),
        .exp_p_dir_o (exp_p_dir_o)
    );

    always #5 clk_i = ~clk_i;

    // Outputs are checked and inputs changed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rstn_i     = 1'b0;
        arb_en_i   = 1'b1;
        hold_max_i = '0;
        req_i      = '0;
        dflt_dat_i = 8'hA0;
        dflt_dir_i = 8'hF0;
        req_mask_i = '0;
        req_dat_i  = '0;
        req_dir_i  = '0;
        repeat (2) tick();
        rstn_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rstn_i = 1'b0;
        #1;
        nvec++; if (gnt_o !== 4'b0000) begin nerr++; $display("FAIL reset_gnt got=%b exp=0000", gnt_o); end
        nvec++; if (busy_o !== 1'b0 || timeout_o !== 1'b0) begin nerr++; $display("FAIL reset_flags busy=%b tmo=%b exp=0/0", busy_o, timeout_o); end
        nvec++; if (lockout_o !== 4'b0000) begin nerr++; $display("FAIL reset_lockout got=%b exp=0000", lockout_o); end
        nvec++; if (exp_p_dat_o !== 8'h00 || exp_p_dir_o !== 8'h00) begin nerr++; $display("FAIL reset_pins dat=%h dir=%h exp=00/00", exp_p_dat_o, exp_p_dir_o); end
    endtask

    task automatic test_basic_grant();
        do_reset();
        nvec++; if (exp_p_dat_o !== 8'hA0 || exp_p_dir_o !== 8'hF0) begin nerr++; $display("FAIL idle_pins dat=%h dir=%h exp=a0/f0", exp_p_dat_o, exp_p_dir_o); end
        req_mask_i[7:0] = 8'h0F;
        req_dat_i[7:0]  = 8'h05;
        req_dir_i[7:0]  = 8'h0F;
        req_i = 4'b0001;
        tick();
        nvec++; if (gnt_o !== 4'b0001 || busy_o !== 1'b1) begin nerr++; $display("FAIL basic_gnt gnt=%b busy=%b exp=0001/1", gnt_o, busy_o); end
        nvec++; if (exp_p_dat_o !== 8'hA0) begin nerr++; $display("FAIL basic_pin_latency dat=%h exp=a0", exp_p_dat_o); end
        tick();
        nvec++; if (exp_p_dat_o !== 8'hA5 || exp_p_dir_o !== 8'hFF) begin nerr++; $display("FAIL basic_pins dat=%h dir=%h exp=a5/ff", exp_p_dat_o, exp_p_dir_o); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        do_reset();
        req_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_g = 4'b0001 << (i % 4);
            tick();
            nvec++; if (gnt_o !== exp_g) begin nerr++; $display("FAIL rr_order%0d got=%b exp=%b", i, gnt_o, exp_g); end
            tick();
            tick();
            nvec++; if (gnt_o !== exp_g) begin nerr++; $display("FAIL rr_hold%0d got=%b exp=%b", i, gnt_o, exp_g); end
            req_i = 4'b1111 & ~exp_g;
            tick();
            nvec++; if (gnt_o !== 4'b0000 || busy_o !== 1'b1) begin nerr++; $display("FAIL rr_release%0d gnt=%b busy=%b exp=0000/1", i, gnt_o, busy_o); end
            req_i = 4'b1111;
            tick();
            nvec++; if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin nerr++; $display("FAIL rr_gap%0d gnt=%b busy=%b exp=0000/0", i, gnt_o, busy_o); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        hold_max_i = 16'd5;
        req_i = 4'b0010;
        tick();
        nvec++; if (gnt_o !== 4'b0010) begin nerr++; $display("FAIL to_gnt got=%b exp=0010", gnt_o); end
        for (int c = 1; c < 5; c++) begin
            tick();
            nvec++; if (gnt_o !== 4'b0010 || timeout_o !== 1'b0) begin nerr++; $display("FAIL to_hold%0d gnt=%b tmo=%b exp=0010/0", c, gnt_o, timeout_o); end
        end
        tick();
        nvec++; if (gnt_o !== 4'b0000 || timeout_o !== 1'b1 || lockout_o !== 4'b0010) begin nerr++; $display("FAIL to_fire gnt=%b tmo=%b lock=%b exp=0000/1/0010", gnt_o, timeout_o, lockout_o); end
        tick();
        nvec++; if (timeout_o !== 1'b0) begin nerr++; $display("FAIL to_pulse tmo=%b exp=0", timeout_o); end
        tick();
        tick();
        nvec++; if (gnt_o !== 4'b0000 || lockout_o !== 4'b0010) begin nerr++; $display("FAIL to_locked gnt=%b lock=%b exp=0000/0010", gnt_o, lockout_o); end
        req_i = 4'b0000;
        tick();
        nvec++; if (lockout_o !== 4'b0000) begin nerr++; $display("FAIL to_unlock lock=%b exp=0000", lockout_o); end
        req_i = 4'b0010;
        tick();
        nvec++; if (gnt_o !== 4'b0010) begin nerr++; $display("FAIL to_regrant got=%b exp=0010", gnt_o); end
    endtask

    task automatic test_arb_disable();
        do_reset();
        req_mask_i[23:16] = 8'hFF;
        req_dat_i[23:16]  = 8'h3C;
        req_dir_i[23:16]  = 8'hFF;
        req_i = 4'b0100;
        tick();
        nvec++; if (gnt_o !== 4'b0100) begin nerr++; $display("FAIL en_gnt got=%b exp=0100", gnt_o); end
        tick();
        nvec++; if (exp_p_dat_o !== 8'h3C || exp_p_dir_o !== 8'hFF) begin nerr++; $display("FAIL en_pins dat=%h dir=%h exp=3c/ff", exp_p_dat_o, exp_p_dir_o); end
        req_dat_i[23:16] = 8'h5A;
        tick();
        nvec++; if (exp_p_dat_o !== 8'h5A) begin nerr++; $display("FAIL en_live dat=%h exp=5a", exp_p_dat_o); end
        arb_en_i = 1'b0;
        tick();
        nvec++; if (gnt_o !== 4'b0000 || busy_o !== 1'b1 || exp_p_dat_o !== 8'h5A) begin nerr++; $display("FAIL en_release gnt=%b busy=%b dat=%h exp=0000/1/5a", gnt_o, busy_o, exp_p_dat_o); end
        tick();
        nvec++; if (exp_p_dat_o !== 8'hA0 || exp_p_dir_o !== 8'hF0 || busy_o !== 1'b0) begin nerr++; $display("FAIL en_dflt dat=%h dir=%h busy=%b exp=a0/f0/0", exp_p_dat_o, exp_p_dir_o, busy_o); end
        tick();
        tick();
        nvec++; if (gnt_o !== 4'b0000 || busy_o !== 1'b0) begin nerr++; $display("FAIL en_nogrant gnt=%b busy=%b exp=0000/0", gnt_o, busy_o); end
        arb_en_i = 1'b1;
        tick();
        nvec++; if (gnt_o !== 4'b0100) begin nerr++; $display("FAIL en_resume got=%b exp=0100", gnt_o); end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_mask_i[23:16] = 8'hFF;
        req_dat_i[23:16]  = 8'h3C;
        req_dir_i[23:16]  = 8'hFF;
        req_i = 4'b0100;
        tick();
        tick();
        nvec++; if (gnt_o !== 4'b0100 || exp_p_dat_o !== 8'h3C) begin nerr++; $display("FAIL ar_pre gnt=%b dat=%h exp=0100/3c", gnt_o, exp_p_dat_o); end
        #3 rstn_i = 1'b0;
        #1;
        nvec++; if (gnt_o !== 4'b0000 || exp_p_dat_o !== 8'h00 || exp_p_dir_o !== 8'h00 || busy_o !== 1'b0) begin nerr++; $display("FAIL ar_clear gnt=%b dat=%h dir=%h busy=%b exp=0000/00/00/0", gnt_o, exp_p_dat_o, exp_p_dir_o, busy_o); end
        req_i = 4'b0101;
        #1 rstn_i = 1'b1;
        tick();
        nvec++; if (gnt_o !== 4'b0001) begin nerr++; $display("FAIL ar_ptr got=%b exp=0001", gnt_o); end
    endtask

    task automatic test_voluntary_vs_timeout();
        do_reset();
        hold_max_i = 16'd3;
        req_i = 4'b0001;
        tick();
        tick();
        tick();
        nvec++; if (gnt_o !== 4'b0001) begin nerr++; $display("FAIL vol_hold got=%b exp=0001", gnt_o); end
        req_i = 4'b0000;
        tick();
        nvec++; if (gnt_o !== 4'b0000 || timeout_o !== 1'b0 || lockout_o !== 4'b0000) begin nerr++; $display("FAIL vol_release gnt=%b tmo=%b lock=%b exp=0000/0/0000", gnt_o, timeout_o, lockout_o); end
        req_i = 4'b0001;
        tick();
        tick();
        nvec++; if (gnt_o !== 4'b0001 || timeout_o !== 1'b0) begin nerr++; $display("FAIL vol_regrant gnt=%b tmo=%b exp=0001/0", gnt_o, timeout_o); end
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_round_robin();
        test_timeout();
        test_arb_disable();
        test_async_reset();
        test_voluntary_vs_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
